// File: rtl/axi_vip_master_wrapper.sv
// AXI4 burst self-test: internal master writes a 16-beat INCR burst into an internal slave memory,
// optionally reads it back and compares. Readback is enabled by defining AXI_VIP_READBACK_EN.

module axi_vip_master #(
   parameter int unsigned MP_AXI_ID_WIDTH     = 1,
   parameter int unsigned MP_AXI_ADDR_WIDTH   = 32,
   parameter int unsigned MP_AXI_DATA_WIDTH   = 32,
   parameter int unsigned MP_AXI_AWUSER_WIDTH = 1,
   parameter int unsigned MP_AXI_ARUSER_WIDTH = 1,
   parameter int unsigned MP_AXI_WUSER_WIDTH  = 1,
   parameter int unsigned MP_AXI_RUSER_WIDTH  = 1,
   parameter int unsigned MP_AXI_BUSER_WIDTH  = 1
) (
   input  logic                             INIT_AXI_TXN,
   output logic                             TXN_DONE,
   output logic                             ERROR,
   input  logic                             M_AXI_ACLK,
   input  logic                             M_AXI_ARESETN,
   output logic [MP_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
   output logic [MP_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [7:0]                       M_AXI_AWLEN,
   output logic [2:0]                       M_AXI_AWSIZE,
   output logic [1:0]                       M_AXI_AWBURST,
   output logic                             M_AXI_AWLOCK,
   output logic [3:0]                       M_AXI_AWCACHE,
   output logic [2:0]                       M_AXI_AWPROT,
   output logic [3:0]                       M_AXI_AWQOS,
   output logic [MP_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
   output logic                             M_AXI_AWVALID,
   input  logic                             M_AXI_AWREADY,
   output logic [MP_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [MP_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                             M_AXI_WLAST,
   output logic [MP_AXI_WUSER_WIDTH-1:0]    M_AXI_WUSER,
   output logic                             M_AXI_WVALID,
   input  logic                             M_AXI_WREADY,
   input  logic [MP_AXI_ID_WIDTH-1:0]       M_AXI_BID,
   input  logic [1:0]                       M_AXI_BRESP,
   input  logic [MP_AXI_BUSER_WIDTH-1:0]    M_AXI_BUSER,
   input  logic                             M_AXI_BVALID,
   output logic                             M_AXI_BREADY,
   output logic [MP_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
   output logic [MP_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [7:0]                       M_AXI_ARLEN,
   output logic [2:0]                       M_AXI_ARSIZE,
   output logic [1:0]                       M_AXI_ARBURST,
   output logic                             M_AXI_ARLOCK,
   output logic [3:0]                       M_AXI_ARCACHE,
   output logic [2:0]                       M_AXI_ARPROT,
   output logic [3:0]                       M_AXI_ARQOS,
   output logic [MP_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
   output logic                             M_AXI_ARVALID,
   input  logic                             M_AXI_ARREADY,
   input  logic [MP_AXI_ID_WIDTH-1:0]       M_AXI_RID,
   input  logic [MP_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                       M_AXI_RRESP,
   input  logic                             M_AXI_RLAST,
   input  logic [MP_AXI_RUSER_WIDTH-1:0]    M_AXI_RUSER,
   input  logic                             M_AXI_RVALID,
   output logic                             M_AXI_RREADY
);

   localparam int unsigned DW       = MP_AXI_DATA_WIDTH;
   localparam int unsigned AW       = MP_AXI_ADDR_WIDTH;
   localparam int unsigned SIZE     = (DW == 64) ? 3 : 2;
   localparam int unsigned IDX_W    = 5;
   localparam logic [31:0] BASE     = 32'h8000_0000;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_COMPARE} state_t;

   state_t              state_q, state_d;
   logic                init_q;
   logic                start_c;
   logic                done_q, error_q;
   logic                awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
   logic                aw_sent_q, ar_sent_q, w_done_q;
   logic [DW-1:0]       wdata_q;
   logic [IDX_W-1:0]    write_index, read_index;
   logic                unused_c;

   // Fixed burst attributes: one 16-beat INCR burst at the base address, ID 0, full strobes
   assign M_AXI_AWID    = '0;
   assign M_AXI_AWADDR  = AW'(BASE);
   assign M_AXI_AWLEN   = 8'd15;
   assign M_AXI_AWSIZE  = 3'(SIZE);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_AWUSER  = '0;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WUSER   = '0;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = AW'(BASE);
   assign M_AXI_ARLEN   = 8'd15;
   assign M_AXI_ARSIZE  = 3'(SIZE);
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'b0011;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;
   assign M_AXI_ARUSER  = '0;

   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WLAST   = wlast_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign TXN_DONE      = done_q;
   assign ERROR         = error_q;

   assign start_c  = INIT_AXI_TXN && !init_q && (state_q == S_IDLE);
   assign unused_c = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP[0], M_AXI_RID, M_AXI_RUSER,
                       M_AXI_RRESP, M_AXI_RDATA, M_AXI_RLAST, M_AXI_ARREADY, ar_sent_q};

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_c) state_d = S_WRITE;
         S_WRITE:   if (M_AXI_BVALID && bready_q) begin
`ifdef AXI_VIP_READBACK_EN
            state_d = S_READ;
`else
            state_d = S_COMPARE;
`endif
         end
         S_READ:    if (M_AXI_RVALID && rready_q && (read_index == IDX_W'(15))) state_d = S_COMPARE;
         S_COMPARE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Channel sequencing, beat counters and result flags
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         init_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_sent_q   <= 1'b0;
         ar_sent_q   <= 1'b0;
         w_done_q    <= 1'b0;
         wdata_q     <= '0;
         write_index <= '0;
         read_index  <= '0;
      end else begin
         init_q <= INIT_AXI_TXN;
         if (start_c) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            aw_sent_q   <= 1'b0;
            ar_sent_q   <= 1'b0;
            w_done_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= DW'(1);
            write_index <= '0;
            read_index  <= '0;
         end else begin
            case (state_q)
               S_WRITE: begin
                  if (awvalid_q && M_AXI_AWREADY) begin
                     awvalid_q <= 1'b0;
                     aw_sent_q <= 1'b1;
                  end else if (!aw_sent_q) begin
                     awvalid_q <= 1'b1;
                  end
                  if (wvalid_q && M_AXI_WREADY) begin
                     if (wlast_q) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        w_done_q <= 1'b1;
                     end else begin
                        write_index <= write_index + IDX_W'(1);
                        wdata_q     <= wdata_q + DW'(1);
                        wlast_q     <= (write_index == IDX_W'(14));
                     end
                  end else if (!w_done_q) begin
                     wvalid_q <= 1'b1;
                  end
                  if (bready_q && M_AXI_BVALID) begin
                     bready_q <= 1'b0;
                     if (M_AXI_BRESP[1]) error_q <= 1'b1;
                  end else begin
                     bready_q <= 1'b1;
                  end
               end
`ifdef AXI_VIP_READBACK_EN
               S_READ: begin
                  if (arvalid_q && M_AXI_ARREADY) begin
                     arvalid_q <= 1'b0;
                     ar_sent_q <= 1'b1;
                  end else if (!ar_sent_q) begin
                     arvalid_q <= 1'b1;
                  end
                  if (rready_q && M_AXI_RVALID) begin
                     if (M_AXI_RRESP[1] ||
                         (M_AXI_RDATA != (DW'(read_index) + DW'(1))) ||
                         (M_AXI_RLAST != (read_index == IDX_W'(15))))
                        error_q <= 1'b1;
                     if (read_index == IDX_W'(15)) rready_q <= 1'b0;
                     else                          read_index <= read_index + IDX_W'(1);
                  end else begin
                     rready_q <= 1'b1;
                  end
               end
`endif
               S_COMPARE: done_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

module axi_vip_slave_mem #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
);

   localparam int unsigned LSB = (DATA_W == 64) ? 3 : 2;

   logic [DATA_W-1:0] mem [16];
   logic [3:0]        widx_q, ridx_q;
   logic [7:0]        rcnt_q, arlen_q;
   logic              aw_busy_q, ar_busy_q;
   logic              unused_c;

   assign bresp    = 2'b00;
   assign rresp    = 2'b00;
   assign unused_c = ^{awaddr, araddr};

   always_ff @(posedge clk) begin
      if (wvalid && wready) mem[widx_q] <= wdata;
   end

   // Write burst: one-cycle AWREADY, WREADY held for the burst, BVALID after WLAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         aw_busy_q <= 1'b0;
         widx_q    <= '0;
      end else begin
         awready <= awvalid && !awready && !aw_busy_q;
         if (awvalid && awready) begin
            aw_busy_q <= 1'b1;
            widx_q    <= awaddr[LSB+3 -: 4];
            wready    <= 1'b1;
         end
         if (wvalid && wready) begin
            widx_q <= widx_q + 4'd1;
            if (wlast) begin
               wready <= 1'b0;
               bvalid <= 1'b1;
            end
         end
         if (bvalid && bready) begin
            bvalid    <= 1'b0;
            aw_busy_q <= 1'b0;
         end
      end
   end

   // Read burst: one-cycle ARREADY, then continuous RVALID with RLAST on the final beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arready   <= 1'b0;
         rvalid    <= 1'b0;
         rlast     <= 1'b0;
         rdata     <= '0;
         ar_busy_q <= 1'b0;
         ridx_q    <= '0;
         rcnt_q    <= '0;
         arlen_q   <= '0;
      end else begin
         arready <= arvalid && !arready && !ar_busy_q;
         if (arvalid && arready) begin
            ar_busy_q <= 1'b1;
            ridx_q    <= araddr[LSB+3 -: 4];
            rdata     <= mem[araddr[LSB+3 -: 4]];
            arlen_q   <= arlen;
            rcnt_q    <= '0;
            rvalid    <= 1'b1;
            rlast     <= (arlen == 8'd0);
         end else if (rvalid && rready) begin
            if (rlast) begin
               rvalid    <= 1'b0;
               rlast     <= 1'b0;
               ar_busy_q <= 1'b0;
            end else begin
               ridx_q <= ridx_q + 4'd1;
               rdata  <= mem[ridx_q + 4'd1];
               rcnt_q <= rcnt_q + 8'd1;
               rlast  <= ((rcnt_q + 8'd1) == arlen_q);
            end
         end
      end
   end

endmodule

module axi_vip_master_wrapper #(
   parameter int unsigned MP_AXI_ID_WIDTH     = 1,
   parameter int unsigned MP_AXI_ADDR_WIDTH   = 32,
   parameter int unsigned MP_AXI_DATA_WIDTH   = 32,
   parameter int unsigned MP_AXI_AWUSER_WIDTH = 1,
   parameter int unsigned MP_AXI_ARUSER_WIDTH = 1,
   parameter int unsigned MP_AXI_WUSER_WIDTH  = 1,
   parameter int unsigned MP_AXI_RUSER_WIDTH  = 1,
   parameter int unsigned MP_AXI_BUSER_WIDTH  = 1
) (
   input  logic ACLK,
   input  logic ARESETN,
   input  logic INIT_AXI_TXN,
   output logic AXI_TXN_DONE,
   output logic AXI_ERROR
);

   localparam int unsigned IDW = MP_AXI_ID_WIDTH;
   localparam int unsigned AW  = MP_AXI_ADDR_WIDTH;
   localparam int unsigned DW  = MP_AXI_DATA_WIDTH;

   logic [IDW-1:0]                  axi_awid, axi_arid;
   logic [AW-1:0]                   axi_awaddr, axi_araddr;
   logic [7:0]                      axi_awlen, axi_arlen;
   logic [2:0]                      axi_awsize, axi_arsize, axi_awprot, axi_arprot;
   logic [1:0]                      axi_awburst, axi_arburst, axi_bresp, axi_rresp;
   logic                            axi_awlock, axi_arlock;
   logic [3:0]                      axi_awcache, axi_arcache, axi_awqos, axi_arqos;
   logic [MP_AXI_AWUSER_WIDTH-1:0]  axi_awuser;
   logic [MP_AXI_ARUSER_WIDTH-1:0]  axi_aruser;
   logic [MP_AXI_WUSER_WIDTH-1:0]   axi_wuser;
   logic [MP_AXI_RUSER_WIDTH-1:0]   axi_ruser;
   logic [MP_AXI_BUSER_WIDTH-1:0]   axi_buser;
   logic [DW-1:0]                   axi_wdata, axi_rdata;
   logic [DW/8-1:0]                 axi_wstrb;
   logic                            axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
   logic                            axi_bvalid, axi_bready, axi_arvalid, axi_arready;
   logic                            axi_rvalid, axi_rready, axi_rlast;
   logic                            unused_c;

   assign axi_buser = '0;
   assign axi_ruser = '0;
   assign unused_c  = ^{axi_awid, axi_arid, axi_awlen, axi_awsize, axi_arsize, axi_awprot, axi_arprot,
                        axi_awburst, axi_arburst, axi_awlock, axi_arlock, axi_awcache, axi_arcache,
                        axi_awqos, axi_arqos, axi_awuser, axi_aruser, axi_wuser, axi_wstrb};

   axi_vip_master #(
      .MP_AXI_ID_WIDTH(MP_AXI_ID_WIDTH), .MP_AXI_ADDR_WIDTH(MP_AXI_ADDR_WIDTH),
      .MP_AXI_DATA_WIDTH(MP_AXI_DATA_WIDTH), .MP_AXI_AWUSER_WIDTH(MP_AXI_AWUSER_WIDTH),
      .MP_AXI_ARUSER_WIDTH(MP_AXI_ARUSER_WIDTH), .MP_AXI_WUSER_WIDTH(MP_AXI_WUSER_WIDTH),
      .MP_AXI_RUSER_WIDTH(MP_AXI_RUSER_WIDTH), .MP_AXI_BUSER_WIDTH(MP_AXI_BUSER_WIDTH)
   ) inst (
      .INIT_AXI_TXN(INIT_AXI_TXN), .TXN_DONE(AXI_TXN_DONE), .ERROR(AXI_ERROR),
      .M_AXI_ACLK(ACLK), .M_AXI_ARESETN(ARESETN),
      .M_AXI_AWID(axi_awid), .M_AXI_AWADDR(axi_awaddr), .M_AXI_AWLEN(axi_awlen),
      .M_AXI_AWSIZE(axi_awsize), .M_AXI_AWBURST(axi_awburst), .M_AXI_AWLOCK(axi_awlock),
      .M_AXI_AWCACHE(axi_awcache), .M_AXI_AWPROT(axi_awprot), .M_AXI_AWQOS(axi_awqos),
      .M_AXI_AWUSER(axi_awuser), .M_AXI_AWVALID(axi_awvalid), .M_AXI_AWREADY(axi_awready),
      .M_AXI_WDATA(axi_wdata), .M_AXI_WSTRB(axi_wstrb), .M_AXI_WLAST(axi_wlast),
      .M_AXI_WUSER(axi_wuser), .M_AXI_WVALID(axi_wvalid), .M_AXI_WREADY(axi_wready),
      .M_AXI_BID('0), .M_AXI_BRESP(axi_bresp), .M_AXI_BUSER(axi_buser),
      .M_AXI_BVALID(axi_bvalid), .M_AXI_BREADY(axi_bready),
      .M_AXI_ARID(axi_arid), .M_AXI_ARADDR(axi_araddr), .M_AXI_ARLEN(axi_arlen),
      .M_AXI_ARSIZE(axi_arsize), .M_AXI_ARBURST(axi_arburst), .M_AXI_ARLOCK(axi_arlock),
      .M_AXI_ARCACHE(axi_arcache), .M_AXI_ARPROT(axi_arprot), .M_AXI_ARQOS(axi_arqos),
      .M_AXI_ARUSER(axi_aruser), .M_AXI_ARVALID(axi_arvalid), .M_AXI_ARREADY(axi_arready),
      .M_AXI_RID('0), .M_AXI_RDATA(axi_rdata), .M_AXI_RRESP(axi_rresp),
      .M_AXI_RLAST(axi_rlast), .M_AXI_RUSER(axi_ruser), .M_AXI_RVALID(axi_rvalid),
      .M_AXI_RREADY(axi_rready)
   );

   axi_vip_slave_mem #(.ADDR_W(AW), .DATA_W(DW)) slv (
      .clk(ACLK), .rst_n(ARESETN),
      .awaddr(axi_awaddr), .awvalid(axi_awvalid), .awready(axi_awready),
      .wdata(axi_wdata), .wlast(axi_wlast), .wvalid(axi_wvalid), .wready(axi_wready),
      .bresp(axi_bresp), .bvalid(axi_bvalid), .bready(axi_bready),
      .araddr(axi_araddr), .arlen(axi_arlen), .arvalid(axi_arvalid), .arready(axi_arready),
      .rdata(axi_rdata), .rresp(axi_rresp), .rlast(axi_rlast), .rvalid(axi_rvalid),
      .rready(axi_rready)
   );

endmodule

// File: tb/tb_axi_vip_master_wrapper.sv
// Randomized self-checking bench for axi_vip_master_wrapper; build with or without AXI_VIP_READBACK_EN.
`timescale 1ns/1ps

module tb_axi_vip_master_wrapper;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   logic INIT_AXI_TXN = 1'b0;
   logic AXI_TXN_DONE, AXI_ERROR;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] model_mem [16];

   axi_vip_master_wrapper dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN),
      .AXI_TXN_DONE(AXI_TXN_DONE), .AXI_ERROR(AXI_ERROR)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One test transaction: start pulse, observe every handshake against the burst rules, check the outcome
   task automatic run_txn(input string tag, input bit frc_bresp, input bit corrupt,
                          input int rst_beat, input bit inject);
      int wbeat, rbeat, aw_n, ar_n, b_n, first_w, last_w, done_cyc, b_cyc, rd_cyc, pulse, inj_off, aw_late;
      logic [31:0] awaddr, araddr, addr;
      bit rd_forced, exp_err, aborted;
      wbeat = 0; rbeat = 0; aw_n = 0; ar_n = 0; b_n = 0; first_w = -1; last_w = -1;
      done_cyc = -1; b_cyc = -1; rd_cyc = 0; inj_off = -1; aw_late = 0;
      awaddr = '0; araddr = '0; rd_forced = 0; aborted = 0;
      exp_err = frc_bresp;
`ifdef AXI_VIP_READBACK_EN
      exp_err = frc_bresp | corrupt;
`endif
      repeat ($urandom_range(1, 4)) @(negedge ACLK);
      INIT_AXI_TXN = 1'b1;
      pulse = $urandom_range(1, 3);
      if (frc_bresp) force dut.axi_bresp = 2'b10;
      for (int cyc = 1; cyc <= 80 && done_cyc < 0 && !aborted; cyc++) begin
         @(negedge ACLK);
`ifdef AXI_VIP_READBACK_EN
         if (rd_forced) begin release dut.axi_rdata; rd_forced = 0; end
`endif
         if (cyc == pulse || cyc == inj_off) INIT_AXI_TXN = 1'b0;
         if (cyc == 1) begin
            check({tag, "_done_clr"}, AXI_TXN_DONE, 1'b0);
            check({tag, "_err_clr"}, AXI_ERROR, 1'b0);
         end
         if (rst_beat >= 0 && wbeat == rst_beat && dut.inst.M_AXI_WVALID && dut.inst.M_AXI_WREADY) begin
            ARESETN = 1'b0;
            INIT_AXI_TXN = 1'b0;
            #1;
            check({tag, "_rst_valids"}, {dut.inst.M_AXI_AWVALID, dut.inst.M_AXI_WVALID,
                  dut.inst.M_AXI_ARVALID, dut.inst.M_AXI_BREADY, dut.inst.M_AXI_RREADY}, 5'b0);
            check({tag, "_rst_done"}, AXI_TXN_DONE, 1'b0);
            check({tag, "_rst_err"}, AXI_ERROR, 1'b0);
            aborted = 1;
         end else begin
            if (dut.inst.M_AXI_AWVALID && dut.inst.M_AXI_AWREADY) begin
               aw_n++;
               awaddr = dut.inst.M_AXI_AWADDR;
               check({tag, "_awaddr"}, awaddr, 32'h8000_0000);
               check({tag, "_awlen"}, dut.inst.M_AXI_AWLEN, 8'd15);
               check({tag, "_awsize_burst"}, {dut.inst.M_AXI_AWSIZE, dut.inst.M_AXI_AWBURST}, {3'd2, 2'b01});
            end
            if (dut.inst.M_AXI_WVALID && dut.inst.M_AXI_WREADY) begin
               addr = awaddr + 32'(4 * wbeat);
               check({tag, "_wdata"}, dut.inst.M_AXI_WDATA, 32'(wbeat + 1));
               check({tag, "_wlast"}, dut.inst.M_AXI_WLAST, (wbeat == 15));
               check({tag, "_windex"}, dut.inst.write_index, 5'(wbeat));
               model_mem[addr[5:2]] = 32'(wbeat + 1);
               if (wbeat == 0) first_w = cyc;
               last_w = cyc;
               wbeat++;
`ifndef AXI_VIP_READBACK_EN
               if (inject && wbeat == 10) begin INIT_AXI_TXN = 1'b1; inj_off = cyc + 2; end
`endif
            end
            if (dut.inst.M_AXI_BVALID && dut.inst.M_AXI_BREADY) begin b_n++; b_cyc = cyc; end
            if (dut.inst.M_AXI_ARVALID || dut.inst.M_AXI_RREADY) rd_cyc++;
`ifdef AXI_VIP_READBACK_EN
            if (dut.inst.M_AXI_ARVALID && dut.inst.M_AXI_ARREADY) begin
               ar_n++;
               araddr = dut.inst.M_AXI_ARADDR;
               check({tag, "_araddr"}, araddr, 32'h8000_0000);
               check({tag, "_arlen"}, dut.inst.M_AXI_ARLEN, 8'd15);
               if (inject) begin INIT_AXI_TXN = 1'b1; inj_off = cyc + 2; end
            end
            if (dut.inst.M_AXI_RVALID && dut.inst.M_AXI_RREADY) begin
               addr = araddr + 32'(4 * rbeat);
               if (corrupt && rbeat == 5) begin
                  force dut.axi_rdata = 32'hDEAD_BEEF;
                  rd_forced = 1;
               end else begin
                  check({tag, "_rdata"}, dut.inst.M_AXI_RDATA, model_mem[addr[5:2]]);
               end
               check({tag, "_rlast"}, dut.inst.M_AXI_RLAST, (rbeat == 15));
               rbeat++;
            end
`endif
            if (AXI_TXN_DONE) begin
               done_cyc = cyc;
               check({tag, "_err_at_done"}, AXI_ERROR, exp_err);
            end
         end
      end
      if (frc_bresp) release dut.axi_bresp;
`ifdef AXI_VIP_READBACK_EN
      if (rd_forced) release dut.axi_rdata;
`endif
      if (aborted) begin
         repeat (2) @(negedge ACLK);
         ARESETN = 1'b1;
         return;
      end
      check({tag, "_done_seen"}, (done_cyc > 0), 1'b1);
      check({tag, "_done_latency"}, (done_cyc > 0 && done_cyc <= 60), 1'b1);
      check({tag, "_done_after_b"}, (done_cyc > b_cyc && b_cyc > 0), 1'b1);
      check({tag, "_aw_count"}, aw_n, 1);
      check({tag, "_w_beats"}, wbeat, 16);
      check({tag, "_w_span"}, last_w - first_w, 15);
      check({tag, "_b_count"}, b_n, 1);
`ifdef AXI_VIP_READBACK_EN
      check({tag, "_ar_count"}, ar_n, 1);
      check({tag, "_r_beats"}, rbeat, 16);
`else
      check({tag, "_rd_idle"}, rd_cyc, 0);
`endif
      repeat (inject ? 40 : 3) begin
         @(negedge ACLK);
         if (dut.inst.M_AXI_AWVALID || dut.inst.M_AXI_WVALID) aw_late++;
      end
      INIT_AXI_TXN = 1'b0;
      check({tag, "_done_hold"}, {AXI_TXN_DONE, AXI_ERROR}, {1'b1, exp_err});
      check({tag, "_no_restart"}, aw_late, 0);
   endtask

   initial begin
      #2;
      check("reset_done", AXI_TXN_DONE, 1'b0);
      check("reset_err", AXI_ERROR, 1'b0);
      check("reset_valids", {dut.inst.M_AXI_AWVALID, dut.inst.M_AXI_WVALID, dut.inst.M_AXI_ARVALID,
                             dut.inst.M_AXI_BREADY, dut.inst.M_AXI_RREADY}, 5'b0);
      #8 ARESETN = 1'b1;
      run_txn("first", 0, 0, -1, 0);
      run_txn("second", 0, 0, -1, 0);
`ifdef AXI_VIP_READBACK_EN
      run_txn("rd_corrupt", 0, 1, -1, 0);
      run_txn("after_corrupt", 0, 0, -1, 0);
`endif
      run_txn("bresp_err", 1, 0, -1, 0);
      run_txn("after_bresp", 0, 0, -1, 0);
      run_txn("rst_beat8", 0, 0, 8, 0);
      run_txn("after_rst", 0, 0, -1, 0);
      run_txn("rst_rand", 0, 0, $urandom_range(2, 14), 0);
      run_txn("after_rst2", 0, 0, -1, 0);
      run_txn("inject", 0, 0, -1, 1);
      for (int i = 0; i < 3; i++) run_txn("rand", ($urandom_range(0, 3) == 0), 0, -1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_vip_master_wrapper.md
# axi_vip_master_wrapper

Self-contained AXI4 burst-test block: an internal AXI4 full master writes one INCR burst of a known pattern into an internal AXI4 slave memory, reads it back and compares. It sits under a simple start/done/error control interface, and serves as the device exercised by the AXI verification environment. The internal slave port is also the attach point for an external slave agent.

## Interface
- MP_AXI_ID_WIDTH, 1: AXI ID width.
- MP_AXI_ADDR_WIDTH, 32: address width.
- MP_AXI_DATA_WIDTH, 32: data width; must be 32 or 64.
- MP_AXI_AWUSER_WIDTH / MP_AXI_ARUSER_WIDTH / MP_AXI_WUSER_WIDTH / MP_AXI_RUSER_WIDTH / MP_AXI_BUSER_WIDTH, 1 each: user widths. User outputs are driven to 0 and user inputs are ignored.
- ACLK  in  1  sole clock, rising edge.
- ARESETN  in  1  reset; asynchronous, active-low.
- INIT_AXI_TXN  in  1  start request; the rising edge is detected.
- AXI_TXN_DONE  out  1  test complete; held high until the next start.
- AXI_ERROR  out  1  sticky error flag; cleared by the next start.
- Master instance name is `inst`. It exposes the M_AXI_* channel signals and `write_index` (current beat, 0-based) for hierarchical monitoring.

## Operation
- Burst parameters:
  - Base address 0x8000_0000.
  - AWLEN/ARLEN = 15, giving 16 beats.
  - Burst type INCR.
  - AWSIZE/ARSIZE = log2(DATA_WIDTH/8).
  - ID = 0, WSTRB all ones.
- Master FSM states: IDLE → WRITE → READ → COMPARE → IDLE.
  - IDLE exits on an INIT_AXI_TXN rising edge. On that edge, DONE and ERROR are cleared and beat counters are reset.
  - WRITE:
    - AW is issued once.
    - 16 W beats carry data = write_index+1, i.e. 0x00000001 through 0x00000010; upper bits are zero for 64-bit.
    - WLAST is asserted on beat 15.
    - After the last beat the master waits for B.
  - READ: AR is issued once, then 16 R beats are accepted with RREADY held high.
  - COMPARE: one cycle. DONE is set, and the FSM returns to IDLE.
- Error sources (each sets AXI_ERROR):
  - BRESP[1] = 1.
  - RRESP[1] = 1.
  - RDATA ≠ read_index+1 on any beat.
  - RLAST missing on beat 15, or present earlier.
- Internal slave:
  - 16-word memory, addressed by address bits [log2(bytes)+3 : log2(bytes)]. Higher address bits are ignored.
  - Accepts one write burst and one read burst at a time.
  - Always returns OKAY, increments the address per beat, and generates RLAST on the last beat.
- A start that arrives while the FSM is not in IDLE is ignored.

## Timing
- Reset values:
  - AXI_TXN_DONE = 0, AXI_ERROR = 0.
  - All master VALID/READY signals = 0, FSM = IDLE, counters = 0.
  - Slave memory contents are undefined.
- Reset mid-burst aborts immediately to IDLE. No completion is signalled.
- Handshakes:
  - VALID is held until READY, and payload is stable while VALID && !READY.
  - AWVALID rises 1 cycle after entering WRITE and drops the cycle after the handshake. The same applies to AR.
  - WVALID may rise together with AWVALID. The slave accepts W only after AW.
  - The slave asserts AWREADY/ARREADY for one cycle, 1 cycle after VALID. WREADY is held high during the burst. BVALID comes 1 cycle after WLAST. RVALID is continuous.
- With no backpressure, the 16-beat write data phase takes 16 consecutive cycles.
- DONE rises within 60 cycles of start.

## Configuration
- AXI_VIP_READBACK_EN:
  - Defined: full flow WRITE → READ → COMPARE, with data checking.
  - Undefined: the READ state is skipped. DONE is set the cycle after B is accepted, ERROR reflects BRESP only, and the read channels stay idle (ARVALID = 0, RREADY = 0).

## Test plan
- Reset low 10 ns, then a 2-cycle INIT pulse → 16 W beats at 0x80000000..0x8000003C with data 0x01..0x10, DONE = 1, ERROR = 0.
- Second INIT after DONE → DONE drops the cycle after the edge, the full sequence repeats, and DONE returns high.
- Force one RDATA beat to 0xDEADBEEF via the slave → ERROR = 1 at DONE. The next INIT clears ERROR.
- Force BRESP = SLVERR (2'b10) → ERROR = 1. DONE still asserts.
- Assert ARESETN low during beat 8 of the write burst → all VALIDs are 0 asynchronously, DONE = 0, ERROR = 0. A fresh INIT completes normally.
- INIT pulse during the READ state → ignored; exactly one DONE results.
